// File: rtl/aes_key_schedule_iter_if.sv
// Bus bundle for the iterative AES key-schedule engine.
//   master : drives start/key_mode/key/rk_idx, observes status and rk_data
//   slave  : the engine itself
// Signals:
//   start      request expansion (sampled only while idle)
//   key_mode   00 AES-128, 01 AES-192, 10 AES-256, 11 illegal
//   key        cipher key, MSB-first, top 32*Nk bits used
//   busy       expansion in progress
//   done       one-cycle pulse on the final word write
//   keys_valid store holds a full schedule for the last accepted key
//   err        one-cycle pulse on a start with an illegal mode
//   rk_idx     round-key index to read
//   rk_data    registered round key rk_idx
interface aes_key_schedule_iter_if;
   logic         start;
   logic [1:0]   key_mode;
   logic [255:0] key;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic         err;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;

   modport master (
      output start, key_mode, key, rk_idx,
      input  busy, done, keys_valid, err, rk_data
   );

   modport slave (
      input  start, key_mode, key, rk_idx,
      output busy, done, keys_valid, err, rk_data
   );
endinterface

// File: rtl/aes_key_schedule_iter.sv
// Iterative AES-128/192/256 key expansion, one 32-bit word per clock through
// a single shared SubWord unit, into an internal word store exposed via a
// registered round-key read port.
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-low reset
//   bus  aes_key_schedule_iter_if.slave (start/done handshake, status,
//        round-key read port)
// Parameter:
//   NK_MAX  largest supported key length in words (4, 6 or 8)
module aes_key_schedule_iter #(
   parameter int NK_MAX = 8
) (
   input logic                     CLK,
   input logic                     RST,
   aes_key_schedule_iter_if.slave  bus
);

   localparam int          NW       = 4 * (NK_MAX + 7);
   localparam logic [3:0]  NK_MAX_L = 4'(NK_MAX);

   typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

   // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box as inverse (x^254, so 0 maps to 0) followed by the affine map;
   // avoids a 256-entry table per byte lane.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int k = 0; k < 7; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   state_t                 state_q;
   logic [3:0]             nk_q;
   logic [3:0]             nr_q;
   logic [5:0]             last_q;    // index of the final word, 4*(Nr+1)-1
   logic [5:0]             i_q;
   logic [2:0]             ph_q;      // i mod Nk, kept as a wrap counter
   logic [7:0]             rcon_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   err_q;
   logic                   kv_q;
   logic [127:0]           rk_q;
   logic [NW-1:0][31:0]    store_q;

   // ---------------- mode decode ----------------
   logic [3:0] nk_sel;
   logic [3:0] nr_sel;
   logic [5:0] last_sel;
   logic       legal;

   always_comb begin
      nk_sel   = 4'd4;
      nr_sel   = 4'd10;
      last_sel = 6'd43;
      case (bus.key_mode)
         2'b01: begin nk_sel = 4'd6; nr_sel = 4'd12; last_sel = 6'd51; end
         2'b10: begin nk_sel = 4'd8; nr_sel = 4'd14; last_sel = 6'd59; end
         default: ;
      endcase
      legal = (bus.key_mode != 2'b11) && (nk_sel <= NK_MAX_L);
   end

   // ---------------- expansion datapath ----------------
   logic [31:0] w_prev;
   logic [31:0] w_back;
   logic [31:0] sub_in;
   logic [31:0] sub_out;
   logic [31:0] temp;
   logic [31:0] w_d;
   logic        at_rcon;
   logic        at_sub;
   logic [7:0]  rcon_d;
   logic [2:0]  ph_d;

   always_comb begin
      w_prev  = store_q[i_q - 6'd1];
      w_back  = store_q[i_q - {2'b00, nk_q}];
      at_rcon = (ph_q == 3'd0);
      at_sub  = (nk_q == 4'd8) && (ph_q == 3'd4);
      // One SubWord serves both the RotWord step and the AES-256 mid-key step
      sub_in  = at_rcon ? {w_prev[23:0], w_prev[31:24]} : w_prev;
      sub_out = sub_word(sub_in);
      if (at_rcon)     temp = sub_out ^ {rcon_q, 24'h0};
      else if (at_sub) temp = sub_out;
      else             temp = w_prev;
      w_d     = w_back ^ temp;
      rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      ph_d    = ({1'b0, ph_q} == nk_q - 4'd1) ? 3'd0 : ph_q + 3'd1;
   end

   // ---------------- read port ----------------
   logic [5:0]   rd_base;
   logic [127:0] rk_d;

   always_comb begin
      rd_base = {bus.rk_idx, 2'b00};
      rk_d    = '0;
      if (bus.rk_idx <= nr_q)
         rk_d = {store_q[rd_base], store_q[rd_base + 6'd1],
                 store_q[rd_base + 6'd2], store_q[rd_base + 6'd3]};
   end

   // ---------------- control + state ----------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         nk_q    <= 4'd4;
         nr_q    <= 4'd0;
         last_q  <= 6'd0;
         i_q     <= 6'd0;
         ph_q    <= 3'd0;
         rcon_q  <= 8'h01;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         kv_q    <= 1'b0;
         rk_q    <= '0;
         store_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         rk_q   <= rk_d;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  kv_q <= 1'b0;
                  if (legal) begin
                     nk_q    <= nk_sel;
                     nr_q    <= nr_sel;
                     last_q  <= last_sel;
                     i_q     <= {2'b00, nk_sel};
                     ph_q    <= 3'd0;
                     rcon_q  <= 8'h01;
                     busy_q  <= 1'b1;
                     state_q <= EXPAND;
                     for (int j = 0; j < NK_MAX; j++)
                        if (4'(j) < nk_sel) store_q[j] <= bus.key[255 - 32*j -: 32];
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            EXPAND: begin
               store_q[i_q] <= w_d;
               i_q          <= i_q + 6'd1;
               ph_q         <= ph_d;
               if (at_rcon) rcon_q <= rcon_d;
               if (i_q == last_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  kv_q    <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.keys_valid = kv_q;
   assign bus.rk_data    = rk_q;

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// Bench for aes_key_schedule_iter: randomized and FIPS-197 keys, expected
// round keys from a word-level reference model, decoupled scoreboard monitor.
module tb_aes_key_schedule_iter;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   aes_key_schedule_iter_if if1 ();
   aes_key_schedule_iter_if if2 ();

   aes_key_schedule_iter #(.NK_MAX(8)) dut  (.CLK(CLK), .RST(RST), .bus(if1));
   aes_key_schedule_iter #(.NK_MAX(4)) dut4 (.CLK(CLK), .RST(RST), .bus(if2));

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] LOWW = 128'hffffffff;
   localparam logic [127:0] ALL  = {128{1'b1}};

   typedef struct { logic [127:0] data; logic [127:0] mask; int tag; int idx; } rd_t;
   typedef struct { logic [1:0] kind; int cyc; int tag; } ev_t;  // kind = {done, err}

   rd_t rd_q[$];
   ev_t ev_q[$];

   int n_pass = 0;
   int n_tot  = 0;
   int cyc    = 0;
   logic rd_req = 1'b0;
   logic rd_vld = 1'b0;

   // ---------------- reference model ----------------
   logic [7:0]  sbox [256];
   logic [31:0] mw [60];
   int          cur_nr = 0;

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   // Walk the multiplicative group with generator 3 and its inverse
   task automatic build_sbox();
      logic [7:0] p, q;
      p = 8'h01; q = 8'h01;
      for (int n = 0; n < 255; n++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         sbox[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
      end
      sbox[0] = 8'h63;
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   task automatic model(input logic [255:0] k, input int nk);
      int nr;
      logic [7:0]  rc;
      logic [31:0] t;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = mw[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk == 8 && i % nk == 4) begin
            t = subw(t);
         end
         mw[i] = mw[i-nk] ^ t;
      end
      cur_nr = nr;
   endtask

   function automatic logic [127:0] exp_rk(input int idx);
      if (idx > cur_nr) return '0;
      return {mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   always @(posedge CLK) begin
      cyc    <= cyc + 1;
      rd_vld <= rd_req;
   end

   // Monitor: pops expectations whenever the DUT presents an event or read data
   always @(negedge CLK) begin
      rd_t r;
      ev_t e;
      if (rd_vld) begin
         if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
         else begin
            r = rd_q.pop_front();
            chk($sformatf("rd_t%0d_i%0d", r.tag, r.idx), if1.rk_data & r.mask, r.data & r.mask);
         end
      end
      if (if1.done || if1.err) begin
         if (ev_q.size() == 0) chk("spurious_evt", {if1.done, if1.err}, 2'b00);
         else begin
            e = ev_q.pop_front();
            chk($sformatf("evt_t%0d", e.tag), {if1.done, if1.err}, e.kind);
            chk($sformatf("evt_cyc_t%0d", e.tag), cyc, e.cyc);
         end
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic issue_start(input logic [255:0] k, input logic [1:0] m, input int tag);
      int nk;
      if1.key = k; if1.key_mode = m; if1.start = 1'b1;
      if (m == 2'b11) begin
         ev_q.push_back('{2'b01, cyc + 1, tag});
      end else begin
         nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
         model(k, nk);
         ev_q.push_back('{2'b10, cyc + 1 + (4*cur_nr + 4 - nk), tag});
      end
      @(negedge CLK);
      if1.start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int n;
      n = 0;
      while (!if1.done && n < lim) begin @(negedge CLK); n++; end
      chk("done_seen", if1.done, 1'b1);
      chk("kv_after_done", if1.keys_valid, 1'b1);
   endtask

   task automatic do_read(input int idx, input logic [127:0] exp, input logic [127:0] mask, input int tag);
      @(negedge CLK);
      if1.rk_idx = 4'(idx);
      rd_req = 1'b1;
      rd_q.push_back('{exp, mask, tag, idx});
      @(negedge CLK);
      rd_req = 1'b0;
   endtask

   task automatic rand_key(output logic [255:0] k);
      for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] k;
      int n;
      build_sbox();
      if1.start = 0; if1.key_mode = 0; if1.key = '0; if1.rk_idx = 0;
      if2.start = 0; if2.key_mode = 0; if2.key = '0; if2.rk_idx = 0;

      // reset state
      repeat (3) @(negedge CLK);
      chk("rst_outs", {if1.busy, if1.done, if1.err, if1.keys_valid, if1.rk_data}, '0);
      chk("rst_outs4", {if2.busy, if2.done, if2.err, if2.keys_valid, if2.rk_data}, '0);
      RST = 1'b1;
      @(negedge CLK);

      // FIPS-197 A.1
      issue_start(K128, 2'b00, 1);
      chk("busy_a1", {if1.busy, if1.keys_valid}, 2'b10);
      wait_done(60);
      do_read(0, K128[255:128], ALL, 1);
      do_read(10, RK10_128, ALL, 1);
      do_read(11, '0, ALL, 1);
      do_read(5, exp_rk(5), ALL, 1);

      // illegal mode: err only, store and read port untouched
      @(negedge CLK);
      issue_start($urandom, 2'b11, 2);
      chk("illegal_busy_kv", {if1.busy, if1.keys_valid}, 2'b00);
      do_read(10, RK10_128, ALL, 2);

      // FIPS-197 A.2
      issue_start(K192, 2'b01, 3);
      wait_done(60);
      do_read(12, 128'h01002202, LOWW, 3);
      do_read(13, '0, ALL, 3);
      do_read(7, exp_rk(7), ALL, 3);

      // FIPS-197 A.3
      issue_start(K256, 2'b10, 4);
      wait_done(60);
      do_read(14, 128'h706c631e, LOWW, 4);
      do_read(0, K256[255:128], ALL, 4);

      // randomized keys and modes
      for (int r = 0; r < 6; r++) begin
         rand_key(k);
         issue_start(k, 2'($urandom_range(0, 2)), 10 + r);
         wait_done(60);
         for (int q = 0; q < 3; q++) begin
            n = $urandom_range(0, 15);
            do_read(n, exp_rk(n), ALL, 10 + r);
         end
      end

      // start while busy is ignored
      issue_start(K128, 2'b00, 20);
      repeat (18) @(negedge CLK);
      rand_key(k);
      if1.key = k; if1.key_mode = 2'b10; if1.start = 1'b1;
      @(negedge CLK);
      if1.start = 1'b0;
      wait_done(60);
      do_read(10, RK10_128, ALL, 20);
      do_read(0, K128[255:128], ALL, 20);

      // start in the done cycle begins a new run
      issue_start(K192, 2'b01, 21);
      wait_done(60);
      issue_start(K256, 2'b10, 22);
      chk("restart_busy", if1.busy, 1'b1);
      wait_done(60);
      do_read(14, 128'h706c631e, LOWW, 22);

      // reset mid-run aborts without done
      issue_start(K256, 2'b10, 23);
      repeat (23) @(negedge CLK);
      chk("busy_mid", if1.busy, 1'b1);
      #2;
      RST = 1'b0;
      ev_q.delete();
      #1;
      chk("rst_mid_outs", {if1.busy, if1.done, if1.err, if1.keys_valid, if1.rk_data}, '0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      repeat (60) @(negedge CLK);
      do_read(0, '0, ALL, 23);
      issue_start(K256, 2'b10, 24);
      wait_done(60);
      do_read(14, 128'h706c631e, LOWW, 24);
      do_read(9, exp_rk(9), ALL, 24);

      // NK_MAX = 4 instance: AES-128 works, AES-256 is illegal
      @(negedge CLK);
      if2.key = K128; if2.key_mode = 2'b00; if2.start = 1'b1;
      @(negedge CLK);
      if2.start = 1'b0;
      n = 1;
      while (!if2.done && n < 60) begin @(negedge CLK); n++; end
      chk("nk4_lat", n, 41);  // accepting edge plus 40 expansion edges
      if2.rk_idx = 4'd10;
      @(negedge CLK);
      chk("nk4_rk10", if2.rk_data, RK10_128);
      if2.key = K256; if2.key_mode = 2'b10; if2.start = 1'b1;
      @(negedge CLK);
      if2.start = 1'b0;
      chk("nk4_err", {if2.err, if2.busy, if2.keys_valid}, 3'b100);
      @(negedge CLK);
      chk("nk4_err_pulse", if2.err, 1'b0);
      chk("nk4_store_kept", if2.rk_data, RK10_128);

      repeat (3) @(negedge CLK);
      chk("ev_q_drained", ev_q.size(), 0);
      chk("rd_q_drained", rd_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/aes_key_schedule_iter.md
# aes_key_schedule_iter

Iterative AES key-schedule engine for AES-128, AES-192 and AES-256. It expands the cipher key one 32-bit word per clock, using a single shared SubWord unit (4 S-boxes), into an internal round-key store. It exposes that store through a registered round-key read port. It sits between key load and the cipher datapath, and replaces the fully combinational 128-bit-only expansion with a smaller multi-mode block that has an explicit start/done handshake.

## Interface
- NK_MAX, default 8: largest supported key length in 32-bit words. Legal values are 4, 6, 8. The word store is sized 4*(NK_MAX+7) words. Modes with Nk > NK_MAX are illegal.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- start  in  1  request expansion. Sampled only in IDLE.
- key_mode  in  2  00 = AES-128 (Nk=4, Nr=10), 01 = AES-192 (Nk=6, Nr=12), 10 = AES-256 (Nk=8, Nr=14), 11 = illegal.
- key  in  256  cipher key, MSB-first. w[0] = key[255:224], w[1] = key[223:192], and so on. Only the top 32*Nk bits are used.
- busy  out  1  high while in EXPAND.
- done  out  1  one-cycle pulse when the last word is written.
- keys_valid  out  1  the store holds a complete schedule for the last accepted key.
- err  out  1  one-cycle pulse when start is given with an illegal mode.
- rk_idx  in  4  round-key index, 0..Nr.
- rk_data  out  128  round key rk_idx, {w[4i], w[4i+1], w[4i+2], w[4i+3]}, registered.

## Operation
- **States:** IDLE, EXPAND.
- **Start accepted in IDLE, legal mode:**
  - Latch Nk and Nr.
  - Write w[0..Nk-1] from key.
  - Set i = Nk and rcon = 0x01.
  - Clear keys_valid; go to EXPAND.
- **Start in IDLE, illegal mode** (key_mode = 11, or Nk > NK_MAX):
  - Pulse err.
  - Clear keys_valid.
  - Leave the store unchanged; stay in IDLE.
- **EXPAND, per cycle,** with temp = w[i-1]:
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon) (0x80 → 0x1b).
  - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
  - Write w[i] = w[i-Nk] ^ temp; i = i + 1.
  - RotWord rotates bytes left ({b1, b2, b3, b0}).
  - Track i mod Nk with a wrap counter. No divider.
- **Final word:** i = 4*(Nr+1) - 1, i.e. word 43, 51 or 59. Its write edge also sets done = 1 and keys_valid = 1, and returns the state to IDLE.
- **start while busy:** ignored. key and key_mode are sampled only at acceptance.
- **Read port:** every edge, rk_data <= store[rk_idx].
  - rk_idx > Nr returns 128'h0.
  - Reads while busy return the current store contents and are not checked.
- **Reset:** async clear.
  - State IDLE.
  - busy, done, err, keys_valid = 0.
  - rk_data = 0; all store words = 0.
  - Reset during EXPAND aborts the expansion with no done pulse.

## Timing
- Start is accepted at edge k.
- w[Nk+j] is written at edge k+1+j.
- The final word and done are at edge k+N, where N = 40 (AES-128), 46 (AES-192), 52 (AES-256).
- busy is high from edge k to edge k+N.
- done is high for exactly one cycle after edge k+N.
- err is high for one cycle after the accepting edge.
- A new start is accepted in the cycle done is high (state is IDLE). Back-to-back expansion is possible with no gap.
- Read latency is 1 cycle: rk_idx at edge t gives rk_data valid after edge t.
- The combinational path per cycle is one 4-S-box SubWord plus two 32-bit XORs.

## Test plan
- **AES-128, FIPS-197 A.1:** key 2b7e1516 28aed2a6 abf71588 09cf4f3c, mode 00 → done 40 cycles after start; rk_idx=10 gives d014f9a8 c9ee2589 e13f0cc8 b6630ca6; rk_idx=0 gives the key.
- **AES-192, FIPS-197 A.2:** key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b, mode 01 → done at 46 cycles; w[51] = 01002202; rk_idx=13 gives 0.
- **AES-256, FIPS-197 A.3:** key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, mode 10 → done at 52 cycles; w[59] = 706c631e.
- **Illegal mode:** mode 11 with start → err pulse 1 cycle, busy stays 0, keys_valid = 0. Repeat with NK_MAX=4 and mode 10 → same response.
- **Busy handling:** start with a different key at cycle 20 of an AES-128 run → ignored, A.1 result intact. Start in the done cycle → a new run begins, busy stays high.
- **Reset mid-operation:** RST low at cycle 25 of an AES-256 run → all outputs 0 immediately, no done pulse. A fresh run after release gives the A.3 results.
